// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU pipeline stages.
//   - OP_W and the opcode encodings carried in the top bits of every packet.
//   - Packet layout, from MSB down: {opcode[OP_W], addr[addr_w], data[data_w]}.
//   - Helper functions that derive the packet width and field offsets.
package cpu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd3;
    localparam logic [OP_W-1:0] OP_AND   = 4'd4;
    localparam logic [OP_W-1:0] OP_OR    = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd6;
    localparam logic [OP_W-1:0] OP_SHL   = 4'd7;
    localparam logic [OP_W-1:0] OP_SHR   = 4'd8;
    localparam logic [OP_W-1:0] OP_STORE = 4'd9;

    // Total packet width for a given data/address width.
    function automatic int pkt_width(input int data_w, input int addr_w);
        return data_w + addr_w + OP_W;
    endfunction

    // Bit index of the MSB of the address field.
    function automatic int addr_msb(input int data_w, input int addr_w);
        return data_w + addr_w - 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO with an occupancy count.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset (pointers and count)
//   push   in   write wdata; ignored when full (count == DEPTH)
//   pop    in   drop the head entry; ignored when empty
//   wdata  in   WIDTH-bit write data
//   rdata  out  WIDTH-bit head entry (valid when count != 0)
//   count  out  number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty use the pre-edge count, so a push into a full FIFO is
    // dropped even if the same edge also pops.
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: pipeline stage between decode and write.
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   complex_data  in   packet {opcode, addr, data} from decode
//   data_write    in   push strobe, one packet per cycle while high
//   pause_out     out  almost-full back-pressure towards decode
//   DAO           out  result packet {opcode, addr, result}
//   dao_valid     out  DAO holds an unconsumed result
//   data_read     in   write stage consumes DAO
//   flag_z        out  last executed result was zero
//   flag_c        out  carry/borrow of the last ADD/SUB/SHL/SHR
//   overflow_err  out  sticky: a push arrived while the FIFO was full
//
// Output handshake: DAO is offered while dao_valid=1 and is consumed on any
// rising edge where data_read=1; data_read is ignored while dao_valid=0.
// A new result may replace DAO on the same edge that consumes the old one.
module execute_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int PKT_W     = DATA_W + ADDR_W + OP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PKT_W-1:0] complex_data,
    input  logic             data_write,
    output logic             pause_out,
    output logic [PKT_W-1:0] DAO,
    output logic             dao_valid,
    input  logic             data_read,
    output logic             flag_z,
    output logic             flag_c,
    output logic             overflow_err
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int ADDR_MSB = addr_msb(DATA_W, ADDR_W);

    logic [PKT_W-1:0]  head;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  next_count;
    logic              push_ok;
    logic              issue;

    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_n;
    logic [DATA_W-1:0] result;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic              c_n;
    logic              z_n;
    logic              alu_op;

    sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_write),
        .pop   (issue),
        .wdata (complex_data),
        .rdata (head),
        .count (count)
    );

    assign push_ok = data_write && (count < CNT_W'(FIFO_DEPTH));
    assign issue   = (count != '0) && (!dao_valid || data_read);

    // Mirror of the FIFO's count update; pause_out is registered from it so
    // decode sees almost-full on the same edge the FIFO reaches it.
    always_comb begin
        next_count = count;
        if (push_ok && !issue) begin
            next_count = count + CNT_W'(1);
        end else if (issue && !push_ok) begin
            next_count = count - CNT_W'(1);
        end
    end

    assign op   = head[PKT_W-1 -: OP_W];
    assign addr = head[ADDR_MSB -: ADDR_W];
    assign d    = head[DATA_W-1:0];
    assign sum  = {1'b0, acc} + {1'b0, d};
    assign diff = {1'b0, acc} - {1'b0, d};

    always_comb begin
        acc_n  = acc;
        c_n    = flag_c;
        z_n    = flag_z;
        result = acc;
        alu_op = 1'b1;
        case (op)
            OP_LOAD: acc_n = d;
            OP_ADD: begin
                acc_n = sum[DATA_W-1:0];
                c_n   = sum[DATA_W];
            end
            OP_SUB: begin
                acc_n = diff[DATA_W-1:0];
                c_n   = diff[DATA_W];
            end
            OP_AND: acc_n = acc & d;
            OP_OR:  acc_n = acc | d;
            OP_XOR: acc_n = acc ^ d;
            OP_SHL: begin
                acc_n = {acc[DATA_W-2:0], 1'b0};
                c_n   = acc[DATA_W-1];
            end
            OP_SHR: begin
                acc_n = {1'b0, acc[DATA_W-1:1]};
                c_n   = acc[0];
            end
            // NOP, STORE and the unused encodings report acc untouched.
            default: alu_op = 1'b0;
        endcase
        if (alu_op) begin
            result = acc_n;
            z_n    = (acc_n == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            DAO          <= '0;
            dao_valid    <= 1'b0;
            flag_z       <= 1'b1;
            flag_c       <= 1'b0;
            overflow_err <= 1'b0;
            pause_out    <= 1'b0;
        end else begin
            pause_out <= (next_count >= CNT_W'(FIFO_DEPTH - 1));
            if (data_write && (count == CNT_W'(FIFO_DEPTH))) begin
                overflow_err <= 1'b1;
            end
            if (issue) begin
                acc       <= acc_n;
                flag_c    <= c_n;
                flag_z    <= z_n;
                DAO       <= {op, addr, result};
                dao_valid <= 1'b1;
            end else if (data_read) begin
                dao_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed self-checking bench for execute_stage.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_execute_stage;

    localparam int PKT_W = 30;

    logic             clk;
    logic             reset;
    logic [PKT_W-1:0] complex_data;
    logic             data_write;
    logic             pause_out;
    logic [PKT_W-1:0] DAO;
    logic             dao_valid;
    logic             data_read;
    logic             flag_z;
    logic             flag_c;
    logic             overflow_err;

    int errors = 0;
    int checks = 0;

    execute_stage dut (
        .clk          (clk),
        .reset        (reset),
        .complex_data (complex_data),
        .data_write   (data_write),
        .pause_out    (pause_out),
        .DAO          (DAO),
        .dao_valid    (dao_valid),
        .data_read    (data_read),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .overflow_err (overflow_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] pkt(input logic [3:0] op,
                                             input logic [11:0] a,
                                             input logic [13:0] d);
        return {op, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [PKT_W-1:0] exp_pkt,
                             input logic exp_z, input logic exp_c);
        check({tag, ".valid"}, {31'd0, dao_valid}, 32'd1);
        check({tag, ".dao"}, {2'd0, DAO}, {2'd0, exp_pkt});
        check({tag, ".z"}, {31'd0, flag_z}, {31'd0, exp_z});
        check({tag, ".c"}, {31'd0, flag_c}, {31'd0, exp_c});
    endtask

    task automatic push(input logic [PKT_W-1:0] p);
        complex_data = p;
        data_write   = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        complex_data = '0;
        data_write   = 1'b0;
        data_read    = 1'b0;
        tick();
        tick();

        // reset state
        check("rst.valid", {31'd0, dao_valid}, 32'd0);
        check("rst.dao", {2'd0, DAO}, 32'd0);
        check("rst.z", {31'd0, flag_z}, 32'd1);
        check("rst.c", {31'd0, flag_c}, 32'd0);
        check("rst.ovf", {31'd0, overflow_err}, 32'd0);
        check("rst.pause", {31'd0, pause_out}, 32'd0);
        reset = 1'b1;
        tick();

        // first LOAD: one edge of latency, no bypass
        push(pkt(4'd1, 12'h000, 14'h0005));
        tick();
        data_write = 1'b0;
        check("load5.nobypass", {31'd0, dao_valid}, 32'd0);
        tick();
        check_out("load5", pkt(4'd1, 12'h000, 14'h0005), 1'b0, 1'b0);

        // LOAD 0x3FFF, ADD 1 with data_read held high -> wrap to zero
        data_read = 1'b1;
        push(pkt(4'd1, 12'h001, 14'h3FFF));
        tick();
        check("pop_only.valid", {31'd0, dao_valid}, 32'd0);
        push(pkt(4'd2, 12'h002, 14'h0001));
        tick();
        data_write = 1'b0;
        check_out("load3fff", pkt(4'd1, 12'h001, 14'h3FFF), 1'b0, 1'b0);
        tick();
        check_out("add_wrap", pkt(4'd2, 12'h002, 14'h0000), 1'b1, 1'b1);
        tick();
        check("drained.valid", {31'd0, dao_valid}, 32'd0);
        check("drained.hold", {2'd0, DAO}, {2'd0, pkt(4'd2, 12'h002, 14'h0000)});

        // LOAD 3, SUB 5 (borrow), STORE 0x0A5
        push(pkt(4'd1, 12'h010, 14'h0003));
        tick();
        push(pkt(4'd3, 12'h011, 14'h0005));
        tick();
        check_out("load3", pkt(4'd1, 12'h010, 14'h0003), 1'b0, 1'b1);
        push(pkt(4'd9, 12'h0A5, 14'h1111));
        tick();
        data_write = 1'b0;
        check_out("sub_borrow", pkt(4'd3, 12'h011, 14'h3FFE), 1'b0, 1'b1);
        tick();
        check_out("store", pkt(4'd9, 12'h0A5, 14'h3FFE), 1'b0, 1'b1);
        data_read = 1'b0;

        // fill the FIFO behind an occupied DAO, then overflow
        push(pkt(4'd6, 12'h001, 14'h0FFF));
        tick();
        check("fill1.pause", {31'd0, pause_out}, 32'd0);
        push(pkt(4'd4, 12'h002, 14'h0F0F));
        tick();
        check("fill2.pause", {31'd0, pause_out}, 32'd0);
        push(pkt(4'd5, 12'h003, 14'h0003));
        tick();
        check("fill3.pause", {31'd0, pause_out}, 32'd1);
        push(pkt(4'd7, 12'h004, 14'h0000));
        tick();
        check("fill4.pause", {31'd0, pause_out}, 32'd1);
        check("fill4.ovf", {31'd0, overflow_err}, 32'd0);
        push(pkt(4'd1, 12'h005, 14'h1234));
        tick();
        data_write = 1'b0;
        check("fill5.ovf", {31'd0, overflow_err}, 32'd1);
        check("fill5.pause", {31'd0, pause_out}, 32'd1);
        check_out("fill5.store_held", pkt(4'd9, 12'h0A5, 14'h3FFE), 1'b0, 1'b1);

        // drain in order, one per cycle
        data_read = 1'b1;
        tick();
        check_out("drain.xor", pkt(4'd6, 12'h001, 14'h3001), 1'b0, 1'b1);
        check("drain1.pause", {31'd0, pause_out}, 32'd1);
        tick();
        check_out("drain.and", pkt(4'd4, 12'h002, 14'h0001), 1'b0, 1'b1);
        check("drain2.pause", {31'd0, pause_out}, 32'd0);
        tick();
        check_out("drain.or", pkt(4'd5, 12'h003, 14'h0003), 1'b0, 1'b1);
        tick();
        check_out("drain.shl", pkt(4'd7, 12'h004, 14'h0006), 1'b0, 1'b0);
        tick();
        check("drain.empty", {31'd0, dao_valid}, 32'd0);
        check("drain.ovf_sticky", {31'd0, overflow_err}, 32'd1);
        tick();
        check("drain.no_dropped", {31'd0, dao_valid}, 32'd0);

        // queue 3 packets behind a valid DAO, then reset mid-operation
        data_read = 1'b0;
        push(pkt(4'd1, 12'h020, 14'h0AAA));
        tick();
        push(pkt(4'd2, 12'h021, 14'h0001));
        tick();
        push(pkt(4'd2, 12'h022, 14'h0001));
        tick();
        push(pkt(4'd2, 12'h023, 14'h0001));
        tick();
        data_write = 1'b0;
        check("prerst.valid", {31'd0, dao_valid}, 32'd1);
        check("prerst.pause", {31'd0, pause_out}, 32'd1);
        reset = 1'b0;
        #2;
        check("asyncrst.valid", {31'd0, dao_valid}, 32'd0);
        check("asyncrst.pause", {31'd0, pause_out}, 32'd0);
        check("asyncrst.ovf", {31'd0, overflow_err}, 32'd0);
        check("asyncrst.z", {31'd0, flag_z}, 32'd1);
        tick();
        reset = 1'b1;
        data_read = 1'b1;
        tick();
        tick();
        check("postrst.no_stale", {31'd0, dao_valid}, 32'd0);
        push(pkt(4'd0, 12'h030, 14'h1234));
        tick();
        data_write = 1'b0;
        tick();
        check_out("postrst.nop_acc0", pkt(4'd0, 12'h030, 14'h0000), 1'b1, 1'b0);
        tick();

        // streaming: push and read every cycle, ADD 0x800 repeatedly
        for (int k = 1; k <= 20; k++) begin
            push(pkt(4'd2, 12'(k), 14'h0800));
            tick();
            check("stream.pause", {31'd0, pause_out}, 32'd0);
            check("stream.ovf", {31'd0, overflow_err}, 32'd0);
            if (k >= 2) begin
                logic [13:0] exp_acc;
                exp_acc = 14'((k - 1) * 32'h800);
                check_out("stream", pkt(4'd2, 12'(k - 1), exp_acc),
                          exp_acc == 14'd0, ((k - 1) % 8) == 0);
            end
        end
        data_write = 1'b0;
        tick();
        check_out("stream.last", pkt(4'd2, 12'd20, 14'((20 * 32'h800))),
                  1'b0, 1'b0);
        tick();
        check("stream.done", {31'd0, dao_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
